// File: rtl/wave_capture_if.sv
// Sample-stream, display-handshake and RAM-write signals of the wave capture block.
// master: the capture block itself; slave: the audio source, display and RAM side.
interface wave_capture_if;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [9:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    modport master (
        input  new_sample_ready,
        input  new_sample_in,
        input  wave_display_idle,
        output write_address,
        output write_enable,
        output write_sample,
        output read_index
    );

    modport slave (
        output new_sample_ready,
        output new_sample_in,
        output wave_display_idle,
        input  write_address,
        input  write_enable,
        input  write_sample,
        input  read_index
    );
endinterface

// File: rtl/wave_capture.sv
// Captures a 512-entry window into the idle half of a double-buffered sample RAM.
// Optional macro WAVE_CAPTURE_DECIMATE_EN writes only every second strobe while capturing.
module wave_capture (
    input logic            clk,
    input logic            reset,
    wave_capture_if.master bus
);

    typedef enum logic [1:0] {StArmed, StActive, StWait} state_e;

    state_e      state_q, state_d;
    logic [8:0]  count_q, count_d;
    logic        prev_neg_q, prev_neg_d;
    logic        read_index_q, read_index_d;
    logic        write_enable_q, write_enable_d;
    logic [9:0]  write_address_q, write_address_d;
    logic [7:0]  write_sample_q, write_sample_d;
    logic        crossing;
    logic        accept;
    logic [7:0]  converted;

`ifdef WAVE_CAPTURE_DECIMATE_EN
    logic phase_q, phase_d;
    assign accept = phase_q;
`else
    assign accept = 1'b1;
`endif

    assign crossing  = bus.new_sample_ready & prev_neg_q & ~bus.new_sample_in[15];
    // Most positive sample maps to row 0 (top of screen).
    assign converted = {bus.new_sample_in[15], ~bus.new_sample_in[14:8]};

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        read_index_d    = read_index_q;
        write_enable_d  = 1'b0;
        write_address_d = write_address_q;
        write_sample_d  = write_sample_q;
        prev_neg_d      = bus.new_sample_ready ? bus.new_sample_in[15] : prev_neg_q;
`ifdef WAVE_CAPTURE_DECIMATE_EN
        phase_d         = phase_q;
`endif

        case (state_q)
            StArmed: begin
                if (crossing) begin
                    write_enable_d  = 1'b1;
                    write_address_d = {~read_index_q, 9'd0};
                    write_sample_d  = converted;
                    count_d         = 9'd1;
                    state_d         = StActive;
`ifdef WAVE_CAPTURE_DECIMATE_EN
                    phase_d         = 1'b0;
`endif
                end
            end
            StActive: begin
                if (bus.new_sample_ready) begin
`ifdef WAVE_CAPTURE_DECIMATE_EN
                    phase_d = ~phase_q;
`endif
                    if (accept) begin
                        write_enable_d  = 1'b1;
                        write_address_d = {~read_index_q, count_q};
                        write_sample_d  = converted;
                        if (&count_q) begin
                            count_d = 9'd0;
                            state_d = StWait;
                        end else begin
                            count_d = count_q + 9'd1;
                        end
                    end
                end
            end
            StWait: begin
                // Swap only while the display is outside the wave region.
                if (bus.wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    count_d      = 9'd0;
                    state_d      = StArmed;
                end
            end
            default: state_d = StArmed;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StArmed;
            count_q         <= 9'd0;
            prev_neg_q      <= 1'b0;
            read_index_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= 10'h200;
            write_sample_q  <= 8'h00;
`ifdef WAVE_CAPTURE_DECIMATE_EN
            phase_q         <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            prev_neg_q      <= prev_neg_d;
            read_index_q    <= read_index_d;
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_sample_q  <= write_sample_d;
`ifdef WAVE_CAPTURE_DECIMATE_EN
            phase_q         <= phase_d;
`endif
        end
    end

    assign bus.write_enable  = write_enable_q;
    assign bus.write_address = write_address_q;
    assign bus.write_sample  = write_sample_q;
    assign bus.read_index    = read_index_q;

endmodule
